sys_array_nxn: RTL

- Parametrised N×N output-stationary systolic matrix multiplier. It is the next generation of the fixed 2×2 array.
- Computes C = A·B, with A of size N×K and B of size K×N. K is set per job at run time.
- Operands stream in one k-step per beat. Row and column skewing is done internally.
- Results drain one C-row per beat over a valid/ready handshake, and a done pulse closes each job.
- Sits between the operand fetch buffers and the result write-back path of the matrix_multiplier subsystem.

---
 rtl/sys_array_pkg.sv | 36 +++
 rtl/sys_array_mac_pe.sv | 59 +++++
 rtl/sys_array_nxn.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/sys_array_pkg.sv
// Shared definitions for the NxN output-stationary systolic array:
// FSM encoding, flush length, clog2 helper and the lane slice macro.
`ifndef SYS_ARRAY_PKG_SV
`define SYS_ARRAY_PKG_SV

`define SA_LANE(vec, idx, w) vec[(idx)*(w) +: (w)]

package sys_array_pkg;

    localparam int SA_STATE_W = 3;

    typedef enum logic [SA_STATE_W-1:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FLUSH = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } sa_state_e;

    function automatic int sa_clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // Last operand needs 2N-2 hops to reach PE(N-1,N-1), plus one cycle to land.
    function automatic int sa_flush_cycles(input int n);
        return 2 * n - 1;
    endfunction

endpackage

`endif

// File: rtl/sys_array_mac_pe.sv
// One multiply-accumulate cell: forwards A right and B down one cycle per hop,
// accumulating the full-precision signed product while the A lane is valid.
module sys_array_mac_pe #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic signed [DATA_W-1:0] a_in,
    input  logic                     a_in_valid,
    input  logic signed [DATA_W-1:0] b_in,
    input  logic                     b_in_valid,
    output logic signed [DATA_W-1:0] a_out,
    output logic                     a_out_valid,
    output logic signed [DATA_W-1:0] b_out,
    output logic                     b_out_valid,
    output logic signed [ACC_W-1:0]  acc
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic signed [DATA_W-1:0]   a_q, b_q;
    logic                       a_v_q, b_v_q;

    // Operands widened before multiplying so the product keeps full precision.
    always_comb begin
        prod  = (2*DATA_W)'(a_in) * (2*DATA_W)'(b_in);
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (a_in_valid) begin
            acc_d = acc_q + ACC_W'(prod);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            a_v_q <= 1'b0;
            b_v_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            a_q   <= a_in;
            b_q   <= b_in;
            a_v_q <= a_in_valid;
            b_v_q <= b_in_valid;
        end
    end

    assign a_out       = a_q;
    assign a_out_valid = a_v_q;
    assign b_out       = b_q;
    assign b_out_valid = b_v_q;
    assign acc         = acc_q;

endmodule

// File: rtl/sys_array_nxn.sv
// NxN output-stationary systolic multiplier C = A*B with run-time K: input skew,
// PE grid, job FSM and row-at-a-time result drain over valid/ready.
module sys_array_nxn
    import sys_array_pkg::*;
#(
    parameter int N      = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int K_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [K_W-1:0]             k_len,
    output logic                       busy,
    input  logic                       a_valid,
    output logic                       a_ready,
    input  logic [N*DATA_W-1:0]        a_data,
    input  logic [N*DATA_W-1:0]        b_data,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [N*ACC_W-1:0]         res_data,
    output logic [sa_clog2(N)-1:0]     res_row,
    output logic                       done
);

    localparam int RW           = sa_clog2(N);
    localparam int FLUSH_CYCLES = sa_flush_cycles(N);

    sa_state_e       state_q, state_d;
    logic [K_W-1:0]  cnt_q, cnt_d;
    logic [K_W-1:0]  klen_q, klen_d;
    logic [RW-1:0]   row_q, row_d;
    logic            clr;

    logic                     inj_v;
    logic signed [DATA_W-1:0] a_inj    [N];
    logic signed [DATA_W-1:0] b_inj    [N];
    logic signed [DATA_W-1:0] a_edge   [N];
    logic signed [DATA_W-1:0] b_edge   [N];
    logic                     a_edge_v [N];
    logic                     b_edge_v [N];

    logic signed [DATA_W-1:0] a_in_w [N][N];
    logic signed [DATA_W-1:0] b_in_w [N][N];
    logic                     a_in_v [N][N];
    logic                     b_in_v [N][N];
    logic signed [DATA_W-1:0] a_h    [N][N];
    logic signed [DATA_W-1:0] b_h    [N][N];
    logic                     a_hv   [N][N];
    logic                     b_hv   [N][N];
    logic signed [ACC_W-1:0]  acc_w  [N][N];

    // Outside an accepted beat the array sees zero data with a cleared valid bit.
    always_comb begin
        inj_v = (state_q == S_LOAD) && a_valid;
        for (int i = 0; i < N; i++) begin
            a_inj[i] = inj_v ? `SA_LANE(a_data, i, DATA_W) : '0;
            b_inj[i] = inj_v ? `SA_LANE(b_data, i, DATA_W) : '0;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_skew
        if (i == 0) begin : g_direct
            assign a_edge[i]   = a_inj[i];
            assign b_edge[i]   = b_inj[i];
            assign a_edge_v[i] = inj_v;
            assign b_edge_v[i] = inj_v;
        end else begin : g_delay
            logic signed [DATA_W-1:0] a_sr_q [i];
            logic signed [DATA_W-1:0] b_sr_q [i];
            logic                     v_sr_q [i];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int s = 0; s < i; s++) begin
                        a_sr_q[s] <= '0;
                        b_sr_q[s] <= '0;
                        v_sr_q[s] <= 1'b0;
                    end
                end else begin
                    a_sr_q[0] <= a_inj[i];
                    b_sr_q[0] <= b_inj[i];
                    v_sr_q[0] <= inj_v;
                    for (int s = 1; s < i; s++) begin
                        a_sr_q[s] <= a_sr_q[s-1];
                        b_sr_q[s] <= b_sr_q[s-1];
                        v_sr_q[s] <= v_sr_q[s-1];
                    end
                end
            end

            assign a_edge[i]   = a_sr_q[i-1];
            assign b_edge[i]   = b_sr_q[i-1];
            assign a_edge_v[i] = v_sr_q[i-1];
            assign b_edge_v[i] = v_sr_q[i-1];
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            if (j == 0) begin : g_a_west
                assign a_in_w[i][j] = a_edge[i];
                assign a_in_v[i][j] = a_edge_v[i];
            end else begin : g_a_hop
                assign a_in_w[i][j] = a_h[i][j-1];
                assign a_in_v[i][j] = a_hv[i][j-1];
            end
            if (i == 0) begin : g_b_north
                assign b_in_w[i][j] = b_edge[j];
                assign b_in_v[i][j] = b_edge_v[j];
            end else begin : g_b_hop
                assign b_in_w[i][j] = b_h[i-1][j];
                assign b_in_v[i][j] = b_hv[i-1][j];
            end

            sys_array_mac_pe #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W)
            ) u_pe (
                .clk         (clk),
                .rst         (rst),
                .clr         (clr),
                .a_in        (a_in_w[i][j]),
                .a_in_valid  (a_in_v[i][j]),
                .b_in        (b_in_w[i][j]),
                .b_in_valid  (b_in_v[i][j]),
                .a_out       (a_h[i][j]),
                .a_out_valid (a_hv[i][j]),
                .b_out       (b_h[i][j]),
                .b_out_valid (b_hv[i][j]),
                .acc         (acc_w[i][j])
            );
        end
    end

    // cnt_q counts accepted beats in LOAD and elapsed cycles in FLUSH.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        klen_d  = klen_q;
        row_d   = row_q;
        clr     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    klen_d  = k_len;
                    cnt_d   = '0;
                    row_d   = '0;
                    clr     = 1'b1;
                    state_d = (k_len != '0) ? S_LOAD : S_DRAIN;
                end
            end
            S_LOAD: begin
                if (a_valid) begin
                    if (cnt_q == klen_q - 1'b1) begin
                        cnt_d   = '0;
                        state_d = S_FLUSH;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                if (cnt_q == K_W'(FLUSH_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (res_ready) begin
                    if (row_q == RW'(N - 1)) begin
                        row_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            klen_q  <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            klen_q  <= klen_d;
            row_q   <= row_d;
        end
    end

    // Accumulators are frozen during DRAIN, so the mux output stays stable under stall.
    always_comb begin
        res_data = '0;
        if (state_q == S_DRAIN) begin
            for (int j = 0; j < N; j++) begin
                `SA_LANE(res_data, j, ACC_W) = acc_w[row_q][j];
            end
        end
    end

    assign busy      = (state_q == S_LOAD) || (state_q == S_FLUSH) || (state_q == S_DRAIN);
    assign a_ready   = (state_q == S_LOAD);
    assign res_valid = (state_q == S_DRAIN);
    assign res_row   = row_q;
    assign done      = (state_q == S_DONE);

endmodule
